// File: rtl/tcm_capture_ctrl_pkg.sv
// Shared types and control-word layout for the TCM stream-capture sequencer.
package tcm_ctrl_pkg;

  // Sequencer states; the encodings are visible to software through STAT_state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_READ    = 3'd4
  } tcm_state_e;

  // Bit positions inside USR_tcm_control.
  localparam int TCM_CTL_RD       = 0;
  localparam int TCM_CTL_RDY      = 1;
  localparam int TCM_CTL_ADDR_LSB = 2;
  localparam int TCM_CTL_ADDR_MSB = 6;

endpackage

// File: rtl/tcm_capture_ctrl.sv
// Capture sequencer for the 32-word TCM: arms/terminates AXI-Stream capture
// through TREADY, counts accepted beats, flags truncated frames and issues
// single-word readback strobes on the TCM read port.
// Optional feature: define TCM_CAPTURE_CTRL_IRQ_EN to enable the level IRQ
// raised on capture completion; otherwise IRQ is tied low.
module tcm_capture_ctrl
  import tcm_ctrl_pkg::*;
#(
  parameter int C_TCM_DEPTH  = 32,
  parameter int C_ADDR_WIDTH = 5
) (
  input  logic                    S_AXIS_ACLK,
  input  logic                    S_AXIS_ARESETN,
  input  logic                    CFG_start,
  input  logic                    CFG_abort,
  input  logic                    CFG_rd_req,
  input  logic [C_ADDR_WIDTH-1:0] CFG_rd_addr,
  input  logic                    CFG_irq_clr,
  input  logic                    S_AXIS_TVALID,
  input  logic                    S_AXIS_TLAST,
  output logic [31:0]             USR_tcm_control,
  output logic [2:0]              STAT_state,
  output logic [5:0]              STAT_count,
  output logic                    STAT_done,
  output logic                    STAT_overflow,
  output logic                    STAT_rd_valid,
  output logic                    IRQ
);

  localparam logic [5:0] DEPTH_CNT = 6'(C_TCM_DEPTH);

  tcm_state_e            state;
  tcm_state_e            state_next;
  logic [5:0]            count;
  logic [5:0]            count_inc;
  logic                  beat;
  logic                  overflow;
  logic                  done_flag;
  logic                  rd_valid;
  logic                  ret_done;
  logic [C_ADDR_WIDTH-1:0] rd_addr;
  logic [4:0]            rd_addr_ext;

  assign beat        = S_AXIS_TVALID && (state == ST_CAPTURE);
  assign count_inc   = count + 6'd1;
  assign rd_addr_ext = 5'(rd_addr);

  // State register; reset drops TREADY at once because it is a decode of state.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state <= ST_IDLE;
    else                 state <= state_next;
  end

  // Next-state logic: start beats read, and DRAIN gives the datapath one idle cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (CFG_start)       state_next = ST_CAPTURE;
        else if (CFG_rd_req) state_next = ST_READ;
      end
      ST_CAPTURE: begin
        if (CFG_abort || (beat && (S_AXIS_TLAST || count_inc == DEPTH_CNT)))
          state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        if (CFG_start)       state_next = ST_CAPTURE;
        else if (CFG_rd_req) state_next = ST_READ;
      end
      ST_READ: state_next = ret_done ? ST_DONE : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control word: TREADY while capturing, strobe plus latched address while reading.
  always_comb begin
    USR_tcm_control = '0;
    USR_tcm_control[TCM_CTL_RDY] = (state == ST_CAPTURE);
    if (state == ST_READ) begin
      USR_tcm_control[TCM_CTL_RD] = 1'b1;
      USR_tcm_control[TCM_CTL_ADDR_MSB:TCM_CTL_ADDR_LSB] = rd_addr_ext;
    end
  end

  // Beat counter, status flags and read-request bookkeeping.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      count     <= '0;
      overflow  <= 1'b0;
      done_flag <= 1'b0;
      rd_valid  <= 1'b0;
      ret_done  <= 1'b0;
      rd_addr   <= '0;
    end else begin
      rd_valid <= (state == ST_READ);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (CFG_start) begin
            count     <= '0;
            overflow  <= 1'b0;
            done_flag <= 1'b0;
          end else if (CFG_rd_req) begin
            rd_addr  <= CFG_rd_addr;
            ret_done <= (state == ST_DONE);
          end
        end
        ST_CAPTURE: begin
          if (beat && count != DEPTH_CNT) count <= count_inc;
          if (beat && !S_AXIS_TLAST && count_inc == DEPTH_CNT) overflow <= 1'b1;
        end
        ST_DRAIN: done_flag <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef TCM_CAPTURE_CTRL_IRQ_EN
  logic irq_q;

  // Completion interrupt: set on DRAIN->DONE, which takes priority over a clear.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN)         irq_q <= 1'b0;
    else if (state == ST_DRAIN)  irq_q <= 1'b1;
    else if (CFG_irq_clr)        irq_q <= 1'b0;
  end

  assign IRQ = irq_q;
`else
  logic irq_clr_unused;
  assign irq_clr_unused = CFG_irq_clr;
  assign IRQ            = 1'b0;
`endif

  assign STAT_state    = state;
  assign STAT_count    = count;
  assign STAT_done     = done_flag;
  assign STAT_overflow = overflow;
  assign STAT_rd_valid = rd_valid;

endmodule

// File: tb/tb_tcm_capture_ctrl.sv
// Scoreboard bench for tcm_capture_ctrl: stimulus queues expected capture
// results and read strobes; a negedge monitor pops and compares them.
module tb_tcm_capture_ctrl;
  import tcm_ctrl_pkg::*;

  logic        S_AXIS_ACLK    = 1'b0;
  logic        S_AXIS_ARESETN = 1'b1;
  logic        CFG_start      = 1'b0;
  logic        CFG_abort      = 1'b0;
  logic        CFG_rd_req     = 1'b0;
  logic [4:0]  CFG_rd_addr    = '0;
  logic        CFG_irq_clr    = 1'b0;
  logic        S_AXIS_TVALID  = 1'b0;
  logic        S_AXIS_TLAST   = 1'b0;
  logic [31:0] USR_tcm_control;
  logic [2:0]  STAT_state;
  logic [5:0]  STAT_count;
  logic        STAT_done;
  logic        STAT_overflow;
  logic        STAT_rd_valid;
  logic        IRQ;

`ifdef TCM_CAPTURE_CTRL_IRQ_EN
  localparam logic EXP_IRQ = 1'b1;
`else
  localparam logic EXP_IRQ = 1'b0;
`endif

  localparam int EV_CAP  = 0;
  localparam int EV_READ = 1;

  typedef struct {
    int kind;
    int count;
    int ovf;
    int addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;
  int   errors = 0;
  int   checks = 0;

  tcm_capture_ctrl dut (
    .S_AXIS_ACLK     (S_AXIS_ACLK),
    .S_AXIS_ARESETN  (S_AXIS_ARESETN),
    .CFG_start       (CFG_start),
    .CFG_abort       (CFG_abort),
    .CFG_rd_req      (CFG_rd_req),
    .CFG_rd_addr     (CFG_rd_addr),
    .CFG_irq_clr     (CFG_irq_clr),
    .S_AXIS_TVALID   (S_AXIS_TVALID),
    .S_AXIS_TLAST    (S_AXIS_TLAST),
    .USR_tcm_control (USR_tcm_control),
    .STAT_state      (STAT_state),
    .STAT_count      (STAT_count),
    .STAT_done       (STAT_done),
    .STAT_overflow   (STAT_overflow),
    .STAT_rd_valid   (STAT_rd_valid),
    .IRQ             (IRQ)
  );

  always #5 S_AXIS_ACLK = ~S_AXIS_ACLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic abort, input logic rd,
                               input logic [4:0] addr, input logic tvalid,
                               input logic tlast, input logic clr);
    CFG_start     = start;
    CFG_abort     = abort;
    CFG_rd_req    = rd;
    CFG_rd_addr   = addr;
    S_AXIS_TVALID = tvalid;
    S_AXIS_TLAST  = tlast;
    CFG_irq_clr   = clr;
    @(posedge S_AXIS_ACLK);
    #1;
    CFG_start     = 1'b0;
    CFG_abort     = 1'b0;
    CFG_rd_req    = 1'b0;
    CFG_rd_addr   = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    CFG_irq_clr   = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expectCapture(input int c, input int o);
    exp_t e;
    e.kind = EV_CAP; e.count = c; e.ovf = o; e.addr = 0;
    sb.push_back(e);
  endtask

  task automatic expectRead(input int a);
    exp_t e;
    e.kind = EV_READ; e.count = 0; e.ovf = 0; e.addr = a;
    sb.push_back(e);
  endtask

  // Monitor: every read strobe and every completion is matched against the scoreboard.
  always @(negedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      prev_done = 1'b0;
    end else begin
      if (USR_tcm_control[TCM_CTL_RD]) begin
        checkOutput("strobe_only_in_read", 32'(STAT_state), 32'd4);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_read: got strobe addr %0d, expected no event",
                   USR_tcm_control[6:2]);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_event_kind_read", 32'(EV_READ), 32'(mon_e.kind));
          checkOutput("sb_read_addr", 32'(USR_tcm_control[6:2]), 32'(mon_e.addr));
        end
      end
      if (STAT_done && !prev_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done: got done count %0d, expected no event",
                   STAT_count);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_event_kind_cap", 32'(EV_CAP), 32'(mon_e.kind));
          checkOutput("sb_cap_count", 32'(STAT_count), 32'(mon_e.count));
          checkOutput("sb_cap_overflow", 32'(STAT_overflow), 32'(mon_e.ovf));
        end
      end
      prev_done = STAT_done;
    end
  end

  initial begin
    // Reset state.
    #1 S_AXIS_ARESETN = 1'b0;
    #2;
    checkOutput("rst_control", USR_tcm_control, 32'h0);
    checkOutput("rst_state", 32'(STAT_state), 32'd0);
    checkOutput("rst_count", 32'(STAT_count), 32'd0);
    checkOutput("rst_done", 32'(STAT_done), 32'd0);
    checkOutput("rst_overflow", 32'(STAT_overflow), 32'd0);
    checkOutput("rst_rd_valid", 32'(STAT_rd_valid), 32'd0);
    checkOutput("rst_irq", 32'(IRQ), 32'd0);
    @(posedge S_AXIS_ACLK); #1;
    S_AXIS_ARESETN = 1'b1;
    idle();

    // 5-beat frame terminated by TLAST.
    expectCapture(5, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_tready_on", USR_tcm_control, 32'h2);
    checkOutput("t1_state_capture", 32'(STAT_state), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, (i == 5), 1'b0);
      if (i < 5) checkOutput("t1_count_running", 32'(STAT_count), 32'(i));
    end
    checkOutput("t1_drain_tready_off", USR_tcm_control, 32'h0);
    checkOutput("t1_state_drain", 32'(STAT_state), 32'd2);
    checkOutput("t1_count", 32'(STAT_count), 32'd5);
    checkOutput("t1_done_not_yet", 32'(STAT_done), 32'd0);
    idle();
    checkOutput("t1_state_done", 32'(STAT_state), 32'd3);
    checkOutput("t1_done", 32'(STAT_done), 32'd1);
    checkOutput("t1_overflow", 32'(STAT_overflow), 32'd0);
    checkOutput("t1_irq_set", 32'(IRQ), 32'(EXP_IRQ));
    idle();
    checkOutput("t1_irq_held", 32'(IRQ), 32'(EXP_IRQ));
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_irq_cleared", 32'(IRQ), 32'd0);

    // Readback of address 3 from DONE.
    expectRead(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_strobe_word", USR_tcm_control, 32'h0000_000D);
    checkOutput("t2_state_read", 32'(STAT_state), 32'd4);
    checkOutput("t2_rd_valid_early", 32'(STAT_rd_valid), 32'd0);
    idle();
    checkOutput("t2_rd_valid", 32'(STAT_rd_valid), 32'd1);
    checkOutput("t2_back_to_done", 32'(STAT_state), 32'd3);
    checkOutput("t2_strobe_gone", USR_tcm_control, 32'h0);
    idle();
    checkOutput("t2_rd_valid_pulse", 32'(STAT_rd_valid), 32'd0);

    // Start and read together from DONE: start wins; then 40 beats, no TLAST.
    expectCapture(32, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_start_wins_state", 32'(STAT_state), 32'd1);
    checkOutput("t3_start_wins_ctl", USR_tcm_control, 32'h2);
    checkOutput("t3_count_cleared", 32'(STAT_count), 32'd0);
    checkOutput("t3_done_cleared", 32'(STAT_done), 32'd0);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      if (i == 31) begin
        checkOutput("t3_count_31", 32'(STAT_count), 32'd31);
        checkOutput("t3_tready_31", USR_tcm_control, 32'h2);
        checkOutput("t3_no_overflow_31", 32'(STAT_overflow), 32'd0);
      end
      if (i == 32) begin
        checkOutput("t3_tready_off_32", USR_tcm_control, 32'h0);
        checkOutput("t3_state_drain", 32'(STAT_state), 32'd2);
      end
      if (i == 33) checkOutput("t3_state_done", 32'(STAT_state), 32'd3);
    end
    checkOutput("t3_count_sat", 32'(STAT_count), 32'd32);
    checkOutput("t3_overflow", 32'(STAT_overflow), 32'd1);

    // Abort in DONE is ignored; abort mid-capture with a beat in the abort cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_abort_in_done", 32'(STAT_state), 32'd3);
    expectCapture(8, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++)
      applyStimulus(1'b0, 1'b0, (i == 3), 5'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_state_drain", 32'(STAT_state), 32'd2);
    checkOutput("t4_count", 32'(STAT_count), 32'd8);
    idle();
    checkOutput("t4_state_done", 32'(STAT_state), 32'd3);
    checkOutput("t4_overflow", 32'(STAT_overflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-capture after 10 beats.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_count_10", 32'(STAT_count), 32'd10);
    #2 S_AXIS_ARESETN = 1'b0;
    #1;
    checkOutput("t5_rst_control", USR_tcm_control, 32'h0);
    checkOutput("t5_rst_count", 32'(STAT_count), 32'd0);
    checkOutput("t5_rst_state", 32'(STAT_state), 32'd0);
    @(posedge S_AXIS_ACLK); #1;
    S_AXIS_ARESETN = 1'b1;
    idle();
    checkOutput("t5_idle_after", 32'(STAT_state), 32'd0);

    // Readback of the top address from IDLE returns to IDLE.
    expectRead(31);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_strobe_word", USR_tcm_control, 32'h0000_007D);
    idle();
    checkOutput("t6_back_to_idle", 32'(STAT_state), 32'd0);
    checkOutput("t6_rd_valid", 32'(STAT_rd_valid), 32'd1);
    checkOutput("t6_irq_never", 32'(IRQ), 32'd0);
    idle();
    idle();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
